// File: rtl/csa8_word_sequencer.sv
// csa8_word_sequencer
//   Drives an external combinational 8-bit carry-select adder to add two
//   WORDS-byte operands one byte per cycle, least-significant byte first.
//   The carry between bytes is chained in a register.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request, accepted only in IDLE
//   op_a, op_b, cin   operands and initial carry, captured on accepted start
//   busy              high while bytes are being added
//   done              one-cycle pulse when result/cout are valid
//   result, cout      registered sum and final carry, held until next start
//   add_a, add_b      byte operands presented to the adder
//   add_cin           carry presented to the adder
//   add_sum, add_cout combinational return from the adder
//
// Optional feature (macro CSA8_SEQ_SUB_EN)
//   Adds input sub. When sub=1 at an accepted start, B is presented inverted
//   and the initial carry is forced to 1, so result = A - B and cout=1 means
//   no borrow. Without the macro the block is addition-only.
module csa8_word_sequencer #(
  parameter int WORDS = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               cin,
`ifdef CSA8_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [8*WORDS-1:0] result,
  output logic               cout,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  output logic               add_cin,
  input  logic [7:0]         add_sum,
  input  logic               add_cout
);

  localparam int OPW = 8 * WORDS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_idx;
  logic             r_carry;
  // Operands are shifted right one byte per RUN cycle so the adder inputs
  // always come straight from the low byte of a register.
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [OPW-1:0]   r_result;
  logic             r_cout;
  logic             w_last;
  logic             w_start_cin;

`ifdef CSA8_SEQ_SUB_EN
  logic r_sub;
  // Subtraction is A + ~B + 1, so the initial carry is forced high.
  assign w_start_cin = sub ? 1'b1 : cin;
  assign add_b       = r_sub ? ~r_b[7:0] : r_b[7:0];
`else
  assign w_start_cin = cin;
  assign add_b       = r_b[7:0];
`endif

  assign add_a   = r_a[7:0];
  assign add_cin = r_carry;
  assign w_last  = (r_idx == CNT_W'(WORDS - 1));

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef CSA8_SEQ_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= w_start_cin;
            r_idx   <= '0;
`ifdef CSA8_SEQ_SUB_EN
            r_sub   <= sub;
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Only the byte at the current index is updated; the others keep
          // whatever they held before this operation.
          for (int k = 0; k < WORDS; k++) begin
            if (r_idx == CNT_W'(k)) r_result[k*8 +: 8] <= add_sum;
          end
          r_carry <= add_cout;
          r_a     <= r_a >> 8;
          r_b     <= r_b >> 8;
          if (w_last) begin
            r_cout  <= add_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa8_word_sequencer.sv
module tb_csa8_word_sequencer;

  localparam int WORDS = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cin;
`ifdef CSA8_SEQ_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;

  always #5 clk = ~clk;

  // External combinational 8-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  csa8_word_sequencer #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef CSA8_SEQ_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] r;
    logic        co;
  } vec_t;

  vec_t        vt[9];
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          bcnt;
  int          ndone;
  logic [31:0] res;
  logic        co;
  logic        done_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. Samples on negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
`ifdef CSA8_SEQ_SUB_EN
    sub   = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = result;
    co  = cout;
    @(negedge clk);
    done_after = done;
  endtask

  initial begin
    vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[2] = '{32'h01010101, 32'h02020202, 1'b0, 32'h03030303, 1'b0};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vt[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vt[5] = '{32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0};
    vt[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    vt[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef CSA8_SEQ_SUB_EN
    sub   = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_result",  result,       32'd0);
    chk("rst_cout",    32'(cout),    32'd0);
    chk("rst_add_a",   32'(add_a),   32'd0);
    chk("rst_add_b",   32'(add_b),   32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;

    // Adder presentation and carry across the byte 0->1 boundary
    @(negedge clk);
    op_a = 32'h000000FF; op_b = 32'h00000001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pres_busy",  32'(busy),    32'd1);
    chk("pres_a0",    32'(add_a),   32'hFF);
    chk("pres_b0",    32'(add_b),   32'h01);
    chk("pres_cin0",  32'(add_cin), 32'd0);
    @(negedge clk);
    chk("pres_a1",    32'(add_a),   32'h00);
    chk("pres_b1",    32'(add_b),   32'h00);
    chk("pres_cin1",  32'(add_cin), 32'd1);
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("pres_lat",    32'(lat), 32'd5);
    chk("pres_result", result,   32'h00000100);
    @(negedge clk);

    // Table-driven additions
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].c, 1'b0);
      chk($sformatf("vec%0d_result", i), res,              vt[i].r);
      chk($sformatf("vec%0d_cout", i),   32'(co),          32'(vt[i].co));
      chk($sformatf("vec%0d_lat", i),    32'(lat),         32'd5);
      chk($sformatf("vec%0d_busy", i),   32'(bcnt),        32'd4);
      chk($sformatf("vec%0d_pulse", i),  32'(done_after),  32'd0);
    end

    // Start while busy is ignored
    @(negedge clk);
    op_a = 32'h000000FF; op_b = 32'h00000001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res   = '0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        start = 1'b1;
        op_a  = 32'h12345678;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        res = result;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_start_ndone",  32'(ndone), 32'd1);
    chk("busy_start_result", res,        32'h00000100);
    chk("busy_start_hold",   result,     32'h00000100);
    chk("busy_start_idle",   32'(busy),  32'd0);

    // Reset in the 2nd RUN cycle aborts
    @(negedge clk);
    op_a = 32'h11111111; op_b = 32'h22222222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   32'(busy),    32'd0);
    chk("abort_done",   32'(done),    32'd0);
    chk("abort_result", result,       32'd0);
    chk("abort_cout",   32'(cout),    32'd0);
    chk("abort_add_a",  32'(add_a),   32'd0);
    chk("abort_cin",    32'(add_cin), 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(32'h01010101, 32'h02020202, 1'b0, 1'b0);
    chk("after_abort_result", res,      32'h03030303);
    chk("after_abort_lat",    32'(lat), 32'd5);

`ifdef CSA8_SEQ_SUB_EN
    // Subtraction
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    chk("sub_5m7_result", res,     32'hFFFFFFFE);
    chk("sub_5m7_cout",   32'(co), 32'd0);
    run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1);
    chk("sub_7m5_result", res,     32'h00000002);
    chk("sub_7m5_cout",   32'(co), 32'd1);
    run_op(32'h00000007, 32'h00000005, 1'b0, 1'b0);
    chk("sub_off_result", res,     32'h0000000C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
